// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch sequencer: opcodes, FSM
// encoding and default bus widths.
package cpu_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 16;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_CALL = 4'hA;
  localparam logic [3:0] OP_RET  = 4'hB;
  localparam logic [3:0] OP_HLT  = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_WAIT,
    ST_DECODE,
    ST_EXEC,
    ST_UPDATE,
    ST_HALT
  } state_t;

endpackage

// File: rtl/ret_stack.sv
// Pointer-based LIFO of return addresses. Overflowing pushes and underflowing
// pops are ignored here; the caller flags them.
module ret_stack #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] count;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] top_idx;

  assign full    = (count == PW'(DEPTH));
  assign empty   = (count == '0);
  assign wr_idx  = AW'(count);
  assign top_idx = AW'(count - PW'(1));
  assign dout    = empty ? '0 : mem[top_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + PW'(1);
    end else if (pop && !empty) begin
      count <= count - PW'(1);
    end
  end

  // Storage needs no reset: entries are only read below the pointer.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch/decode sequencer driving the PC. Define RET_STACK_EN to
// add CALL/RET with a hardware return stack; otherwise 0xA/0xB are ALU ops.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] execadd,
  output logic              loadPC,
  output logic              incPC,
  output logic [ADDR_W-1:0] address,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir,
  output logic              exec_start,
  input  logic              exec_done,
  input  logic              zero_flag,
  input  logic              resume,
  output logic              halted,
  output logic              stack_err
);

  state_t            state;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand;

  assign opcode  = ir[DATA_W-1 -: 4];
  assign operand = ir[ADDR_W-1:0];

`ifdef RET_STACK_EN
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [ADDR_W-1:0] top;
  logic [ADDR_W-1:0] ret_addr;

  assign ret_addr = execadd + ADDR_W'(1);
  assign push     = (state == ST_DECODE) && (opcode == OP_CALL) && !full;
  assign pop      = (state == ST_DECODE) && (opcode == OP_RET) && !empty;

  ret_stack #(
    .W     (ADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (ret_addr),
    .dout  (top),
    .full  (full),
    .empty (empty)
  );
`else
  assign stack_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_FETCH;
      loadPC     <= 1'b0;
      incPC      <= 1'b0;
      address    <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      ir         <= '0;
      exec_start <= 1'b0;
      halted     <= 1'b0;
`ifdef RET_STACK_EN
      stack_err  <= 1'b0;
`endif
    end else begin
      // PC pulses and exec_start are single-cycle by construction.
      loadPC     <= 1'b0;
      incPC      <= 1'b0;
      exec_start <= 1'b0;
      case (state)
        ST_FETCH: begin
          mem_addr <= execadd;
          mem_req  <= 1'b1;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_ack) begin
            ir      <= mem_rdata;
            mem_req <= 1'b0;
            state   <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          state <= ST_UPDATE;
          case (opcode)
            OP_NOP: incPC <= 1'b1;
            OP_JMP: begin
              loadPC  <= 1'b1;
              address <= operand;
            end
            OP_JZ: begin
              if (zero_flag) begin
                loadPC  <= 1'b1;
                address <= operand;
              end else begin
                incPC <= 1'b1;
              end
            end
            OP_HLT: begin
              halted <= 1'b1;
              state  <= ST_HALT;
            end
`ifdef RET_STACK_EN
            OP_CALL: begin
              loadPC  <= 1'b1;
              address <= operand;
              if (full) stack_err <= 1'b1;
            end
            OP_RET: begin
              if (empty) begin
                incPC     <= 1'b1;
                stack_err <= 1'b1;
              end else begin
                loadPC  <= 1'b1;
                address <= top;
              end
            end
`endif
            default: begin
              exec_start <= 1'b1;
              state      <= ST_EXEC;
            end
          endcase
        end
        ST_EXEC: begin
          if (exec_done) begin
            incPC <= 1'b1;
            state <= ST_UPDATE;
          end
        end
        ST_UPDATE: state <= ST_FETCH;
        ST_HALT: begin
          if (resume) begin
            halted <= 1'b0;
            incPC  <= 1'b1;
            state  <= ST_UPDATE;
          end
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule
